// File: rtl/decre_sched_pkg.sv
// rtl/decre_sched_pkg.sv - shared types and owner encodings for the decrement scheduler
package decre_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Owner encodings double as the datapath operand select (dec_cin)
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/decre_sched_if.sv
// rtl/decre_sched_if.sv - requester, result and datapath signals of the decrement scheduler
interface decre_sched_if #(
  parameter int N = 4
);

  logic         req_a;
  logic [N-1:0] opa;
  logic [N-1:0] cnt_a;
  logic         ack_a;
  logic         req_b;
  logic [N-1:0] opb;
  logic [N-1:0] cnt_b;
  logic         ack_b;
  logic [N-1:0] res;
  logic         res_cout;
  logic         res_zero;
  logic         busy;
  logic [N-1:0] dec_a;
  logic [N-1:0] dec_b;
  logic         dec_cin;
  logic [N-1:0] dec_y;
  logic         dec_cout;
  logic         dec_zout;

  modport slave (
    input  req_a, opa, cnt_a, req_b, opb, cnt_b, dec_y, dec_cout, dec_zout,
    output ack_a, ack_b, res, res_cout, res_zero, busy, dec_a, dec_b, dec_cin
  );

  modport master (
    output req_a, opa, cnt_a, req_b, opb, cnt_b, dec_y, dec_cout, dec_zout,
    input  ack_a, ack_b, res, res_cout, res_zero, busy, dec_a, dec_b, dec_cin
  );

endinterface

// File: rtl/decre_rr_arb.sv
// rtl/decre_rr_arb.sv - two-input round-robin arbiter; pointer advances only on grant
module decre_rr_arb
  import decre_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic grant_en,
  output logic owner
);

  logic last_q;

  always_comb begin
    owner = OWN_A;
    if (req_a && req_b) begin
      owner = ~last_q;
    end else if (req_b) begin
      owner = OWN_B;
    end
  end

  // Reset pretends B was served last so A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_B;
    end else if (grant_en) begin
      last_q <= owner;
    end
  end

endmodule

// File: rtl/decre_sched.sv
// rtl/decre_sched.sv - time-shares one decrement datapath between requesters A and B
module decre_sched
  import decre_sched_pkg::*;
#(
  parameter int N = 4
) (
  input logic          clk,
  input logic          rst,
  decre_sched_if.slave bus
);

  state_e       state_q;
  logic         owner_q;
  logic [N-1:0] acc_q;
  logic [N-1:0] rem_q;
  logic         borrow_q;
  logic         ack_a_q;
  logic         ack_b_q;
  logic [N-1:0] res_q;
  logic         res_cout_q;
  logic         res_zero_q;
  logic         busy_q;

  logic         grant_en;
  logic         arb_owner;
  logic [N-1:0] op_d;
  logic [N-1:0] cnt_d;
  logic         borrow_d;

  assign grant_en = (state_q == IDLE) && (bus.req_a || bus.req_b);
  assign op_d     = (arb_owner == OWN_B) ? bus.opb : bus.opa;
  assign cnt_d    = (arb_owner == OWN_B) ? bus.cnt_b : bus.cnt_a;
  assign borrow_d = borrow_q | bus.dec_cout;

  decre_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_a    (bus.req_a),
    .req_b    (bus.req_b),
    .grant_en (grant_en),
    .owner    (arb_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_A;
      acc_q      <= '0;
      rem_q      <= '0;
      borrow_q   <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
      res_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            owner_q  <= arb_owner;
            acc_q    <= op_d;
            rem_q    <= cnt_d;
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            if (cnt_d != '0) begin
              state_q <= STEP;
            end else begin
              // Zero-step job completes without touching the datapath
              state_q    <= DONE;
              res_q      <= op_d;
              res_cout_q <= 1'b0;
              res_zero_q <= (op_d == '0);
              ack_a_q    <= (arb_owner == OWN_A);
              ack_b_q    <= (arb_owner == OWN_B);
            end
          end
        end
        STEP: begin
          acc_q    <= bus.dec_y;
          borrow_q <= borrow_d;
          rem_q    <= rem_q - N'(1);
          if (rem_q == N'(1)) begin
            state_q    <= DONE;
            res_q      <= bus.dec_y;
            res_cout_q <= borrow_d;
            res_zero_q <= bus.dec_zout;
            ack_a_q    <= (owner_q == OWN_A);
            ack_b_q    <= (owner_q == OWN_B);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath is driven from acc only while stepping; the idle port reads 0
  assign bus.dec_cin  = (state_q == STEP) && (owner_q == OWN_B);
  assign bus.dec_a    = ((state_q == STEP) && (owner_q == OWN_A)) ? acc_q : '0;
  assign bus.dec_b    = ((state_q == STEP) && (owner_q == OWN_B)) ? acc_q : '0;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.res      = res_q;
  assign bus.res_cout = res_cout_q;
  assign bus.res_zero = res_zero_q;
  assign bus.busy     = busy_q;

endmodule
